jtkiwi_colmix: RTL

//  Final video stage downstream of the object line buffer. Each pixel it merges the 9-bit object

---
 rtl/jtkiwi_colmix_pkg.sv | 16 +
 rtl/jtkiwi_colmix_if.sv | 25 ++
 rtl/jtframe_dual_ram16.sv | 37 +++
 rtl/jtkiwi_colmix.sv | 96 +++++++++
 4 files changed

// File: rtl/jtkiwi_colmix_pkg.sv
// Shared constants and helpers for the colour mixer.
//  TRANSP_COL : colour index that marks an object pixel as see-through
//  PAL_AW     : palette entry address width (512 entries of 16 bits)
package jtkiwi_colmix_pkg;

  localparam logic [3:0]  TRANSP_COL = 4'd0;
  localparam int unsigned PAL_AW     = 9;

  typedef logic [PAL_AW-1:0] pal_addr_t;

  // Object wins only when its colour is non-transparent and objects are not hidden.
  function automatic logic obj_opaque(input logic [8:0] pxl, input logic hide);
    return (pxl[3:0] != TRANSP_COL) && !hide;
  endfunction

endpackage

// File: rtl/jtkiwi_colmix_if.sv
// CPU palette bus between the main CPU decoder and the colour mixer.
//  cpu_addr : palette byte address, bit0 selects low/high byte
//  cpu_dout : CPU write data
//  cpu_we   : write strobe, qualified with pal_cs
//  pal_cs   : palette chip select
//  cpu_din  : palette read data back to the CPU
interface jtkiwi_colmix_if;

  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_we;
  logic       pal_cs;
  logic [7:0] cpu_din;

  modport master (
    output cpu_addr, cpu_dout, cpu_we, pal_cs,
    input  cpu_din
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_we, pal_cs,
    output cpu_din
  );

endinterface

// File: rtl/jtframe_dual_ram16.sv
// 512 x 16 dual-port palette RAM.
//  Port 0 (CPU)  : byte-lane writes via we0, registered read enabled by re0 -> q0
//  Port 1 (video): registered read every clk -> q1
// Reads return the contents before any write on the same clk edge.
// Only the read registers are reset; the array keeps its contents.
module jtframe_dual_ram16
  import jtkiwi_colmix_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  pal_addr_t   addr0,
  input  logic [15:0] data0,
  input  logic [1:0]  we0,
  input  logic        re0,
  output logic [15:0] q0,
  input  pal_addr_t   addr1,
  output logic [15:0] q1
);

  logic [15:0] mem [0:(1<<PAL_AW)-1];

  always_ff @(posedge clk) begin
    if (we0[0]) mem[addr0][7:0]  <= data0[7:0];
    if (we0[1]) mem[addr0][15:8] <= data0[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      if (re0) q0 <= mem[addr0];
      q1 <= mem[addr1];
    end
  end

endmodule

// File: rtl/jtkiwi_colmix.sv
// Final colour stage: object/tile priority, palette lookup, blanking.
//  clk, rst_n       : system clock, async active-low reset
//  pxl_cen          : pixel enable; must not be high on two consecutive clks so the
//                     1-clk palette read settles between pixel edges
//  LHBL, LVBL       : blanking in (active low); LHBL_dly/LVBL_dly delayed by BLANK_DLY pixels
//  obj_pxl, scr_pxl : {pal[4:0], col[3:0]} from object and tile layers
//  cpu              : palette CPU bus (byte writes, 1-clk registered byte reads)
//  red/green/blue   : 5-bit colour, forced to 0 while blanked
//  debug_bus        : [0] hides objects, [1] hides tiles
// Pixel latency is two pxl_cen edges: address register, then output register.
module jtkiwi_colmix
  import jtkiwi_colmix_pkg::*;
#(
  parameter int unsigned BLANK_DLY = 2  // must match the pixel latency (>= 2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [8:0] obj_pxl,
  input  logic [8:0] scr_pxl,
  jtkiwi_colmix_if.slave cpu,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly,
  input  logic [7:0] debug_bus
);

  pal_addr_t             pal_addr_d, pal_addr_q;
  logic [15:0]           cpu_q, vid_q;
  logic [1:0]            cpu_we_b;
  logic                  cpu_re;
  logic                  lane_q;
  logic [BLANK_DLY-1:0]  lhbl_q, lvbl_q;
  logic [14:0]           rgb_q;
  logic                  vis;
  logic                  unused_bits;

  always_comb begin
    pal_addr_d = scr_pxl;
    if (obj_opaque(obj_pxl, debug_bus[0])) begin
      pal_addr_d = obj_pxl;
    end else if (debug_bus[1]) begin
      pal_addr_d = '0;
    end
  end

  assign cpu_we_b = {2{cpu.pal_cs & cpu.cpu_we}} & {cpu.cpu_addr[0], ~cpu.cpu_addr[0]};
  assign cpu_re   = cpu.pal_cs & ~cpu.cpu_we;

  jtframe_dual_ram16 u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr0 (cpu.cpu_addr[9:1]),
    .data0 ({2{cpu.cpu_dout}}),
    .we0   (cpu_we_b),
    .re0   (cpu_re),
    .q0    (cpu_q),
    .addr1 (pal_addr_q),
    .q1    (vid_q)
  );

  // Blanking stage feeding the output register sees the same pixel as vid_q.
  assign vis = lhbl_q[BLANK_DLY-2] & lvbl_q[BLANK_DLY-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_addr_q <= '0;
      lhbl_q     <= '0;
      lvbl_q     <= '0;
      rgb_q      <= '0;
      lane_q     <= 1'b0;
    end else begin
      if (cpu_re) lane_q <= cpu.cpu_addr[0];
      if (pxl_cen) begin
        pal_addr_q <= pal_addr_d;
        lhbl_q     <= {lhbl_q[BLANK_DLY-2:0], LHBL};
        lvbl_q     <= {lvbl_q[BLANK_DLY-2:0], LVBL};
        rgb_q      <= vis ? vid_q[14:0] : '0;
      end
    end
  end

  assign red          = rgb_q[14:10];
  assign green        = rgb_q[9:5];
  assign blue         = rgb_q[4:0];
  assign LHBL_dly     = lhbl_q[BLANK_DLY-1];
  assign LVBL_dly     = lvbl_q[BLANK_DLY-1];
  assign cpu.cpu_din  = lane_q ? cpu_q[15:8] : cpu_q[7:0];

  assign unused_bits = ^{debug_bus[7:2], vid_q[15]};

endmodule
